// File: rtl/smag_pkg.sv
// Shared types for the sign-magnitude add/subtract scheduler.
// Carries the default magnitude width, the operand struct and the FSM state encoding.
package smag_pkg;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic             sign;
        logic [WIDTH-1:0] mag;
    } smag_t;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        SUM,
        DIF,
        RESP
    } state_t;

endpackage

// File: rtl/smag_mag_addsub.sv
// Shared WIDTH-bit magnitude unit: Kogge-Stone adder/subtractor plus magnitude comparator.
// Subtraction is x + ~y + 1, so cout is the "no borrow" flag when sub=1.
module smag_mag_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             gt,
    output logic             eq
);

    localparam int LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_ye;
    logic [WIDTH-1:0] w_hs;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic [WIDTH-1:0] w_c;

    // Each level merges (G,P) pairs at distance 2^l; after LEVELS levels
    // bit i holds the group generate/propagate over [i:0].
    always_comb begin
        // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
        w_ye = sub ? ~y : y;
        w_hs = x ^ w_ye;
        w_g  = x & w_ye;
        w_p  = w_hs;
        w_gn = w_g;
        w_pn = w_p;
        for (int l = 0; l < LEVELS; l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = (1 << l); i < WIDTH; i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i-(1 << l)]);
                w_pn[i] = w_p[i] & w_p[i-(1 << l)];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
    end

    assign w_c    = {w_g[WIDTH-2:0] | (w_p[WIDTH-2:0] & {(WIDTH-1){sub}}), sub};
    assign result = w_hs ^ w_c;
    assign cout   = w_g[WIDTH-1] | (w_p[WIDTH-1] & sub);

    assign gt = (x > y);
    assign eq = (x == y);

endmodule

// File: rtl/smag_addsub_sched.sv
// Round-robin scheduler that time-shares one magnitude add/sub unit between NREQ requesters,
// producing the sign-magnitude sum and difference of each accepted operand pair.
module smag_addsub_sched #(
    parameter int WIDTH = smag_pkg::WIDTH,
    parameter int NREQ  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_a,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_b,
    output logic [NREQ-1:0]             req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [WIDTH:0]              rsp_s,
    output logic [WIDTH:0]              rsp_d,
    output logic                        rsp_sc,
    output logic                        rsp_dc,
    output logic                        busy
);

    import smag_pkg::*;

    localparam int IDW = $clog2(NREQ);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_b;
    logic [WIDTH:0]   r_s;
    logic [WIDTH:0]   r_d;
    logic             r_sc;
    logic             r_dc;
    logic             r_agt;
    logic             r_eq;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last;

    logic             w_gnt_any;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_gnt_hot;
    logic [WIDTH:0]   w_sel_a;
    logic [WIDTH:0]   w_sel_b;
    logic             w_xfer;
    int               w_cand;

    logic [WIDTH-1:0] w_ux;
    logic [WIDTH-1:0] w_uy;
    logic             w_usub;
    logic [WIDTH-1:0] w_ures;
    logic             w_ucout;
    logic             w_ugt;
    logic             w_ueq;

    logic             w_sx;
    logic             w_sy;
    logic             w_same;
    logic             w_rsign;
    logic             w_rc;

    // Round-robin: scan starting one past the last winner, first valid requester wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_hot = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(r_last) + 1 + k;
            if (w_cand >= NREQ)
                w_cand = w_cand - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!w_gnt_any && (j == w_cand) && req_valid[j]) begin
                    w_gnt_any    = 1'b1;
                    w_gnt_idx    = IDW'(j);
                    w_gnt_hot[j] = 1'b1;
                    w_sel_a      = req_a[j*(WIDTH+1) +: WIDTH+1];
                    w_sel_b      = req_b[j*(WIDTH+1) +: WIDTH+1];
                end
            end
        end
    end

    assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt_hot : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_xfer) w_next = CMP;
            CMP:     w_next = SUM;
            SUM:     w_next = DIF;
            DIF:     w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // DIF is A + (-B): only B's effective sign changes.
    assign w_sx   = r_a[WIDTH];
    assign w_sy   = (r_state == DIF) ? ~r_b[WIDTH] : r_b[WIDTH];
    assign w_same = (w_sx == w_sy);

    // Unlike signs subtract smaller from larger, using the flags registered in CMP.
    always_comb begin
        w_ux   = '0;
        w_uy   = '0;
        w_usub = 1'b0;
        if (r_state == CMP) begin
            w_ux = r_a[WIDTH-1:0];
            w_uy = r_b[WIDTH-1:0];
        end else if ((r_state == SUM) || (r_state == DIF)) begin
            w_usub = ~w_same;
            if (w_same || r_agt || r_eq) begin
                w_ux = r_a[WIDTH-1:0];
                w_uy = r_b[WIDTH-1:0];
            end else begin
                w_ux = r_b[WIDTH-1:0];
                w_uy = r_a[WIDTH-1:0];
            end
        end
    end

    smag_mag_addsub #(
        .WIDTH (WIDTH)
    ) u_mag (
        .x      (w_ux),
        .y      (w_uy),
        .sub    (w_usub),
        .result (w_ures),
        .cout   (w_ucout),
        .gt     (w_ugt),
        .eq     (w_ueq)
    );

    // A zero magnitude is always +0 unless it is the wrapped result of an overflow.
    always_comb begin
        w_rc    = w_same & w_ucout;
        w_rsign = 1'b0;
        if (w_same) begin
            if (w_ucout || (|w_ures))
                w_rsign = w_sx;
        end else if (!r_eq) begin
            w_rsign = r_agt ? w_sx : w_sy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_id   <= '0;
            r_last <= IDW'(NREQ - 1);
            r_agt  <= 1'b0;
            r_eq   <= 1'b0;
            r_s    <= '0;
            r_sc   <= 1'b0;
            r_d    <= '0;
            r_dc   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_id   <= w_gnt_idx;
                r_last <= w_gnt_idx;
            end
            if (r_state == CMP) begin
                r_agt <= w_ugt;
                r_eq  <= w_ueq;
            end
            if (r_state == SUM) begin
                r_s  <= {w_rsign, w_ures};
                r_sc <= w_rc;
            end
            if (r_state == DIF) begin
                r_d  <= {w_rsign, w_ures};
                r_dc <= w_rc;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_id    = r_id;
    assign rsp_s     = r_s;
    assign rsp_d     = r_d;
    assign rsp_sc    = r_sc;
    assign rsp_dc    = r_dc;

endmodule
